// File: rtl/cmos_dvp_tx_if.sv
// DVP pixel bus: frame sync, line valid and pixel byte.
interface cmos_dvp_tx_if;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;

    modport master (output cam_vsync, cam_href, cam_data);
    modport slave  (input  cam_vsync, cam_href, cam_data);
endinterface

// File: rtl/cmos_dvp_tx.sv
// DVP test-pattern source: OV5640-style RGB565 byte stream, high byte first.
// Stands in for a camera sensor in front of the capture path.
module cmos_dvp_tx #(
    parameter int unsigned H_PIXEL   = 1024,
    parameter int unsigned V_PIXEL   = 768,
    parameter int unsigned H_BLANK   = 64,
    parameter int unsigned VSYNC_CYC = 32,
    parameter int unsigned V_FRONT   = 128,
    parameter int unsigned V_BACK    = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          pattern_sel,
    input  logic [15:0]         solid_rgb,
    cmos_dvp_tx_if.master       dvp,
    output logic                frame_done,
    output logic [15:0]         frame_cnt
);

    localparam int unsigned LineBytes = 2 * H_PIXEL;
    localparam int unsigned M0        = (VSYNC_CYC > V_FRONT) ? VSYNC_CYC : V_FRONT;
    localparam int unsigned M1        = (H_BLANK > V_BACK) ? H_BLANK : V_BACK;
    localparam int unsigned M2        = (M0 > M1) ? M0 : M1;
    localparam int unsigned CntMax    = (M2 > LineBytes) ? M2 : LineBytes;
    localparam int unsigned CntW      = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned BarW      = H_PIXEL / 8;
    localparam int unsigned BarCntW   = (BarW > 1) ? $clog2(BarW) : 1;

    typedef enum logic [2:0] {StIdle, StVsync, StVFront, StActive, StHBlank, StVBack} state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic [11:0]          x_q;
    logic [10:0]          y_q;
    logic [15:0]          inc_q;
    logic [BarCntW-1:0]   bar_cnt_q;
    logic [2:0]           bar_idx_q;
    logic                 last_line_q;
    logic [1:0]           pat_q;
    logic [15:0]          solid_q;
    logic                 vsync_q;
    logic                 href_q;
    logic [7:0]           data_q;
    logic                 frame_done_q;
    logic [15:0]          frame_cnt_q;

    logic [15:0]          pix;
    logic                 hb_end;
    logic                 vb_last_next;
    logic                 start_frame;

    assign dvp.cam_vsync = vsync_q;
    assign dvp.cam_href  = href_q;
    assign dvp.cam_data  = data_q;
    assign frame_done    = frame_done_q;
    assign frame_cnt     = frame_cnt_q;

    // Pixel value for the current (x, y) under the pattern latched at frame start.
    always_comb begin
        pix = 16'h0000;
        case (pat_q)
            2'd0: begin
                case (bar_idx_q)
                    3'd0:    pix = 16'hFFFF;
                    3'd1:    pix = 16'hFFE0;
                    3'd2:    pix = 16'h07FF;
                    3'd3:    pix = 16'h07E0;
                    3'd4:    pix = 16'hF81F;
                    3'd5:    pix = 16'hF800;
                    3'd6:    pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            end
            2'd1:    pix = inc_q;
            2'd2:    pix = (x_q[5] ^ y_q[5]) ? 16'hFFFF : 16'h0000;
            default: pix = solid_q;
        endcase
    end

    // Frame-boundary decodes; frame_done is loaded so it is high during the last V_BACK cycle.
    always_comb begin
        hb_end = (state_q == StHBlank) && (cnt_q == CntW'(H_BLANK - 1));
        if (V_BACK == 1) begin
            vb_last_next = hb_end && last_line_q;
        end else begin
            vb_last_next = (state_q == StVBack) && (cnt_q == CntW'(V_BACK - 2));
        end
        start_frame = en && ((state_q == StIdle) ||
                             ((state_q == StVBack) && (cnt_q == CntW'(V_BACK - 1))));
    end

    // Timing FSM with registered outputs; data register is loaded one byte ahead of the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            inc_q        <= '0;
            bar_cnt_q    <= '0;
            bar_idx_q    <= '0;
            last_line_q  <= 1'b0;
            pat_q        <= '0;
            solid_q      <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            frame_done_q <= vb_last_next;
            if (vb_last_next) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            case (state_q)
                StIdle: begin
                    vsync_q <= 1'b0;
                    href_q  <= 1'b0;
                    data_q  <= '0;
                end
                StVsync: begin
                    if (cnt_q == CntW'(VSYNC_CYC - 1)) begin
                        state_q <= StVFront;
                        vsync_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StVFront: begin
                    if (cnt_q == CntW'(V_FRONT - 1)) begin
                        state_q <= StActive;
                        href_q  <= 1'b1;
                        data_q  <= pix[15:8];
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StActive: begin
                    if (cnt_q == CntW'(LineBytes - 1)) begin
                        state_q   <= StHBlank;
                        href_q    <= 1'b0;
                        data_q    <= '0;
                        cnt_q     <= '0;
                        x_q       <= '0;
                        bar_cnt_q <= '0;
                        bar_idx_q <= '0;
                        // Advance y now so the next line's first byte sees the new row.
                        if (y_q == 11'(V_PIXEL - 1)) begin
                            last_line_q <= 1'b1;
                        end else begin
                            y_q <= y_q + 11'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (!cnt_q[0]) begin
                            // Next byte is the low byte; pixel position steps after it.
                            data_q <= pix[7:0];
                            x_q    <= x_q + 12'd1;
                            inc_q  <= inc_q + 16'd1;
                            if (bar_cnt_q == BarCntW'(BarW - 1)) begin
                                bar_cnt_q <= '0;
                                bar_idx_q <= bar_idx_q + 3'd1;
                            end else begin
                                bar_cnt_q <= bar_cnt_q + BarCntW'(1);
                            end
                        end else begin
                            data_q <= pix[15:8];
                        end
                    end
                end
                StHBlank: begin
                    if (hb_end) begin
                        cnt_q <= '0;
                        if (last_line_q) begin
                            state_q <= StVBack;
                        end else begin
                            state_q <= StActive;
                            href_q  <= 1'b1;
                            data_q  <= pix[15:8];
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StVBack: begin
                    if (cnt_q == CntW'(V_BACK - 1)) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
            // Frame start overrides the transitions above and latches the pattern.
            if (start_frame) begin
                state_q     <= StVsync;
                vsync_q     <= 1'b1;
                href_q      <= 1'b0;
                data_q      <= '0;
                cnt_q       <= '0;
                x_q         <= '0;
                y_q         <= '0;
                inc_q       <= '0;
                bar_cnt_q   <= '0;
                bar_idx_q   <= '0;
                last_line_q <= 1'b0;
                pat_q       <= pattern_sel;
                solid_q     <= solid_rgb;
            end
        end
    end

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// Directed bench for cmos_dvp_tx with a byte scoreboard and sync-edge recorder.
module tb_cmos_dvp_tx;

    localparam int unsigned HP = 64;
    localparam int unsigned VP = 4;
    localparam int unsigned HB = 4;
    localparam int unsigned VS = 3;
    localparam int unsigned VF = 2;
    localparam int unsigned VB = 2;
    localparam int FrameBytes = 2 * HP * VP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_rgb = 16'h0000;
    logic        frame_done;
    logic [15:0] frame_cnt;

    cmos_dvp_tx_if dvp_if ();

    cmos_dvp_tx #(
        .H_PIXEL   (HP),
        .V_PIXEL   (VP),
        .H_BLANK   (HB),
        .VSYNC_CYC (VS),
        .V_FRONT   (VF),
        .V_BACK    (VB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .dvp         (dvp_if),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rel_cyc = 0;
    logic vs_prev = 1'b0;
    logic hr_prev = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    int vs_rise_q[$];
    int vs_fall_q[$];
    int hr_rise_q[$];
    int hr_fall_q[$];
    int fd_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pix_model(input int pat, input logic [15:0] solid,
                                              input int x, input int y);
        logic [15:0] v;
        int bar;
        case (pat)
            0: begin
                bar = x / (HP / 8);
                case (bar)
                    0:       v = 16'hFFFF;
                    1:       v = 16'hFFE0;
                    2:       v = 16'h07FF;
                    3:       v = 16'h07E0;
                    4:       v = 16'hF81F;
                    5:       v = 16'hF800;
                    6:       v = 16'h001F;
                    default: v = 16'h0000;
                endcase
            end
            1:       v = 16'((y * HP + x) % 65536);
            2:       v = (((x / 32) % 2) != ((y / 32) % 2)) ? 16'hFFFF : 16'h0000;
            default: v = solid;
        endcase
        return v;
    endfunction

    task automatic push_frame(input int pat, input logic [15:0] solid);
        logic [15:0] p;
        for (int y = 0; y < VP; y++) begin
            for (int x = 0; x < HP; x++) begin
                p = pix_model(pat, solid, x, y);
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[7:0]);
            end
        end
    endtask

    task automatic clear_rec();
        cap_q.delete();
        vs_rise_q.delete();
        vs_fall_q.delete();
        hr_rise_q.delete();
        hr_fall_q.delete();
        fd_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic int qsize(input int which);
        case (which)
            0:       return vs_rise_q.size();
            1:       return hr_rise_q.size();
            default: return fd_q.size();
        endcase
    endfunction

    task automatic wait_count(input int which, input int target, input int limit,
                              input string tag);
        int i;
        i = 0;
        while (qsize(which) < target && i < limit) begin
            tick(1);
            i++;
        end
        check(tag, 32'(qsize(which) >= target), 32'd1);
    endtask

    function automatic logic [31:0] outs();
        return 32'({dvp_if.cam_vsync, dvp_if.cam_href, dvp_if.cam_data, frame_done, frame_cnt});
    endfunction

    // Sink side: sample on the falling edge, record sync edges, score href bytes.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (dvp_if.cam_vsync && !vs_prev) vs_rise_q.push_back(cyc);
                if (!dvp_if.cam_vsync && vs_prev) vs_fall_q.push_back(cyc);
                if (dvp_if.cam_href && !hr_prev) hr_rise_q.push_back(cyc);
                if (!dvp_if.cam_href && hr_prev) hr_fall_q.push_back(cyc);
                if (frame_done) fd_q.push_back(cyc);
                if (dvp_if.cam_href) begin
                    cap_q.push_back(dvp_if.cam_data);
                    check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        check("sb_data", 32'(dvp_if.cam_data), 32'(exp_q.pop_front()));
                    end
                end else begin
                    check("data_idle_zero", 32'(dvp_if.cam_data), 32'd0);
                end
                vs_prev = dvp_if.cam_vsync;
                hr_prev = dvp_if.cam_href;
            end else begin
                vs_prev = 1'b0;
                hr_prev = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset and idle with en low.
        tick(5);
        check("rst_outputs", outs(), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            check("idle_quiet", outs(), 32'd0);
        end
        check("idle_no_vsync", 32'(vs_rise_q.size()), 32'd0);

        // Three back-to-back incrementing frames; en dropped during the third.
        clear_rec();
        pattern_sel = 2'd1;
        for (int f = 0; f < 3; f++) push_frame(1, 16'h0000);
        en = 1'b1;
        wait_count(2, 2, 1500, "wait_fd2");
        tick(3);
        en = 1'b0;
        wait_count(2, 3, 1500, "wait_fd3");
        tick(50);
        check("vs_count", 32'(vs_rise_q.size()), 32'd3);
        check("vs_width", 32'(vs_fall_q[0] - vs_rise_q[0]), 32'(VS));
        check("front_porch", 32'(hr_rise_q[0] - vs_fall_q[0]), 32'(VF));
        check("hr_count", 32'(hr_rise_q.size()), 32'd12);
        for (int i = 0; i < 4; i++) begin
            check("href_width", 32'(hr_fall_q[i] - hr_rise_q[i]), 32'd128);
        end
        for (int i = 0; i < 3; i++) begin
            check("href_gap", 32'(hr_rise_q[i + 1] - hr_fall_q[i]), 32'(HB));
        end
        check("frame_period0", 32'(vs_rise_q[1] - vs_rise_q[0]), 32'd535);
        check("frame_period1", 32'(vs_rise_q[2] - vs_rise_q[1]), 32'd535);
        check("fd_count", 32'(fd_q.size()), 32'd3);
        check("fd_last_vback", 32'(fd_q[0] - hr_fall_q[3]), 32'(HB + VB - 1));
        check("frame_cnt3", 32'(frame_cnt), 32'd3);
        check("sb_drained_inc", 32'(exp_q.size()), 32'd0);
        check("cap_size_inc", 32'(cap_q.size()), 32'(3 * FrameBytes));
        check("inc_px1_lo", 32'(cap_q[3]), 32'h01);
        check("inc_l1p0_hi", 32'(cap_q[128]), 32'h00);
        check("inc_l1p0_lo", 32'(cap_q[129]), 32'h40);
        check("inc_last_hi", 32'(cap_q[510]), 32'h00);
        check("inc_last_lo", 32'(cap_q[511]), 32'hFF);
        check("inc_restart", 32'(cap_q[FrameBytes + 3]), 32'h01);

        // Single colour-bar frame.
        clear_rec();
        pattern_sel = 2'd0;
        push_frame(0, 16'h0000);
        en = 1'b1;
        wait_count(0, 1, 20, "wait_vs_bars");
        en = 1'b0;
        wait_count(2, 1, 1000, "wait_fd_bars");
        tick(20);
        check("bar0_hi", 32'(cap_q[0]), 32'hFF);
        check("bar0_lo", 32'(cap_q[1]), 32'hFF);
        check("bar0_p7", 32'(cap_q[15]), 32'hFF);
        check("bar1_hi", 32'(cap_q[16]), 32'hFF);
        check("bar1_lo", 32'(cap_q[17]), 32'hE0);
        check("bar7_hi", 32'(cap_q[112]), 32'h00);
        check("bar7_lo", 32'(cap_q[113]), 32'h00);
        check("bar1_l3_lo", 32'(cap_q[3 * 128 + 17]), 32'hE0);
        check("bars_vs_count", 32'(vs_rise_q.size()), 32'd1);
        check("frame_cnt4", 32'(frame_cnt), 32'd4);
        check("sb_drained_bars", 32'(exp_q.size()), 32'd0);

        // Solid frame with pattern, colour and en all changed during line 2.
        clear_rec();
        pattern_sel = 2'd3;
        solid_rgb = 16'h1234;
        push_frame(3, 16'h1234);
        en = 1'b1;
        wait_count(1, 3, 2000, "wait_line2");
        tick(20);
        pattern_sel = 2'd2;
        solid_rgb = 16'hABCD;
        en = 1'b0;
        wait_count(2, 1, 2000, "wait_fd_mid");
        tick(300);
        check("mid_vs_count", 32'(vs_rise_q.size()), 32'd1);
        check("mid_hr_count", 32'(hr_rise_q.size()), 32'd4);
        check("mid_fd_count", 32'(fd_q.size()), 32'd1);
        check("frame_cnt5", 32'(frame_cnt), 32'd5);
        check("sb_drained_mid", 32'(exp_q.size()), 32'd0);
        check("mid_l2_end_hi", 32'(cap_q[2 * 128 + 126]), 32'h12);
        check("mid_l3_lo", 32'(cap_q[3 * 128 + 1]), 32'h34);
        check("mid_idle_out", 32'({dvp_if.cam_vsync, dvp_if.cam_href, dvp_if.cam_data}), 32'd0);

        // Asynchronous reset during an active line, then a fresh frame.
        clear_rec();
        pattern_sel = 2'd1;
        push_frame(1, 16'h0000);
        en = 1'b1;
        wait_count(1, 2, 2000, "wait_line1");
        tick(10);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", outs(), 32'd0);
        exp_q.delete();
        tick(3);
        clear_rec();
        push_frame(1, 16'h0000);
        rel_cyc = cyc;
        rst_n = 1'b1;
        wait_count(0, 1, 20, "wait_vs_rst");
        en = 1'b0;
        wait_count(2, 1, 1000, "wait_fd_rst");
        tick(20);
        check("rst_vs_start", 32'(vs_rise_q[0] - rel_cyc), 32'd1);
        check("rst_vs_width", 32'(vs_fall_q[0] - vs_rise_q[0]), 32'(VS));
        check("rst_hr_count", 32'(hr_rise_q.size()), 32'd4);
        check("frame_cnt_rst", 32'(frame_cnt), 32'd1);
        check("sb_drained_rst", 32'(exp_q.size()), 32'd0);
        check("rst_l1p0_lo", 32'(cap_q[129]), 32'h40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
